// File: rtl/vgg16_pkg.sv
// ============================================================================
//  Module  : vgg16_pkg
//  Purpose : Shared sizing constants, score/index typedefs and the state
//            encoding used by the classification stage of the VGG16 pipeline.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vgg16_pkg;

  localparam int NUM_CLASSES = 1000;
  localparam int DATA_W      = 16;
  localparam int IDX_W       = $clog2(NUM_CLASSES);

  typedef logic signed [DATA_W-1:0] score_t;
  typedef logic        [IDX_W-1:0]  class_idx_t;

  // IDLE: no partial frame held (beat counter is 0).
  // ACCUM: at least one beat of the current frame has been taken.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage : vgg16_pkg

`default_nettype wire

// File: rtl/fc_top2_update.sv
// ============================================================================
//  Module  : fc_top2_update
//  Purpose : Combinational best/second-best update for one incoming score.
//            Reusable by any top-k style tracker.
//  Ports   : top1_*/top2_*/top2_valid - current working registers
//            new_score/new_idx        - candidate being folded in
//            nxt_*                    - updated working registers
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_top2_update #(
  parameter int DATA_W = vgg16_pkg::DATA_W,
  parameter int IDX_W  = vgg16_pkg::IDX_W
) (
  input  logic signed [DATA_W-1:0] top1_score,
  input  logic        [IDX_W-1:0]  top1_idx,
  input  logic signed [DATA_W-1:0] top2_score,
  input  logic        [IDX_W-1:0]  top2_idx,
  input  logic                     top2_valid,
  input  logic signed [DATA_W-1:0] new_score,
  input  logic        [IDX_W-1:0]  new_idx,
  output logic signed [DATA_W-1:0] nxt_top1_score,
  output logic        [IDX_W-1:0]  nxt_top1_idx,
  output logic signed [DATA_W-1:0] nxt_top2_score,
  output logic        [IDX_W-1:0]  nxt_top2_idx,
  output logic                     nxt_top2_valid
);

  // Strict signed compares: a later class equal to an earlier one never
  // displaces it, so ties resolve to the lower index in both places.
  always_comb begin
    nxt_top1_score = top1_score;
    nxt_top1_idx   = top1_idx;
    nxt_top2_score = top2_score;
    nxt_top2_idx   = top2_idx;
    nxt_top2_valid = top2_valid;
    if (new_score > top1_score) begin
      nxt_top2_score = top1_score;
      nxt_top2_idx   = top1_idx;
      nxt_top1_score = new_score;
      nxt_top1_idx   = new_idx;
      nxt_top2_valid = 1'b1;
    end else if (!top2_valid || (new_score > top2_score)) begin
      nxt_top2_score = new_score;
      nxt_top2_idx   = new_idx;
      nxt_top2_valid = 1'b1;
    end
  end

endmodule : fc_top2_update

`default_nettype wire

// File: rtl/fc_argmax_top2.sv
// ============================================================================
//  Module  : fc_argmax_top2
//  Purpose : Tracks the highest and second-highest score (with class index)
//            across a frame of NUM_CLASSES signed scores and publishes them
//            with a one-cycle valid_result pulse after the last beat.
//  Ports   : clk, rst          - clock, synchronous active-high reset
//            valid_in/score_in - one score per beat, in class order
//            clear             - abort the frame in progress
//            busy              - a frame is partially consumed
//            valid_result      - new result pulse
//            class_idx/score   - best class
//            second_idx/score  - runner-up class
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_argmax_top2 #(
  parameter int NUM_CLASSES = vgg16_pkg::NUM_CLASSES,
  parameter int DATA_W      = vgg16_pkg::DATA_W,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] score_in,
  input  logic                     clear,
  output logic                     busy,
  output logic                     valid_result,
  output logic        [IDX_W-1:0]  class_idx,
  output logic signed [DATA_W-1:0] class_score,
  output logic        [IDX_W-1:0]  second_idx,
  output logic signed [DATA_W-1:0] second_score
);

  import vgg16_pkg::*;

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_CLASSES - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_cnt;

  logic signed [DATA_W-1:0] r_top1_score;
  logic        [IDX_W-1:0]  r_top1_idx;
  logic signed [DATA_W-1:0] r_top2_score;
  logic        [IDX_W-1:0]  r_top2_idx;
  logic                     r_top2_valid;

  logic signed [DATA_W-1:0] w_top1_score;
  logic        [IDX_W-1:0]  w_top1_idx;
  logic signed [DATA_W-1:0] w_top2_score;
  logic        [IDX_W-1:0]  w_top2_idx;
  logic                     w_top2_valid;

  logic                     r_valid_result;
  logic        [IDX_W-1:0]  r_class_idx;
  logic signed [DATA_W-1:0] r_class_score;
  logic        [IDX_W-1:0]  r_second_idx;
  logic signed [DATA_W-1:0] r_second_score;

  logic                     w_beat;
  logic                     w_last;

  // clear has priority over a coincident beat, which is dropped.
  assign w_beat = valid_in && !clear;
  // The counter is zero in IDLE and NUM_CLASSES >= 2, so the last beat is
  // always taken in ACCUM.
  assign w_last = w_beat && (r_state == ACCUM) && (r_cnt == c_LAST);

  fc_top2_update #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_update (
    .top1_score     (r_top1_score),
    .top1_idx       (r_top1_idx),
    .top2_score     (r_top2_score),
    .top2_idx       (r_top2_idx),
    .top2_valid     (r_top2_valid),
    .new_score      (score_in),
    .new_idx        (r_cnt),
    .nxt_top1_score (w_top1_score),
    .nxt_top1_idx   (w_top1_idx),
    .nxt_top2_score (w_top2_score),
    .nxt_top2_idx   (w_top2_idx),
    .nxt_top2_valid (w_top2_valid)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_beat) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (clear || w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------- counter and working set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_top1_score <= '0;
      r_top1_idx   <= '0;
      r_top2_score <= '0;
      r_top2_idx   <= '0;
      r_top2_valid <= 1'b0;
    end else if (clear) begin
      // Working registers are simply reloaded by the next first beat.
      r_cnt <= '0;
    end else if (valid_in) begin
      r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
      if (r_state == IDLE) begin
        r_top1_score <= score_in;
        r_top1_idx   <= '0;
        r_top2_valid <= 1'b0;
      end else begin
        r_top1_score <= w_top1_score;
        r_top1_idx   <= w_top1_idx;
        r_top2_score <= w_top2_score;
        r_top2_idx   <= w_top2_idx;
        r_top2_valid <= w_top2_valid;
      end
    end
  end

  // ----------------------------------------------------- published result
  // Loads the post-update view on the last beat, so the pulse and the
  // fields line up one cycle after that beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_result <= 1'b0;
      r_class_idx    <= '0;
      r_class_score  <= '0;
      r_second_idx   <= '0;
      r_second_score <= '0;
    end else begin
      r_valid_result <= w_last;
      if (w_last) begin
        r_class_idx    <= w_top1_idx;
        r_class_score  <= w_top1_score;
        r_second_idx   <= w_top2_idx;
        r_second_score <= w_top2_score;
      end
    end
  end

  assign busy         = (r_state == ACCUM);
  assign valid_result = r_valid_result;
  assign class_idx    = r_class_idx;
  assign class_score  = r_class_score;
  assign second_idx   = r_second_idx;
  assign second_score = r_second_score;

endmodule : fc_argmax_top2

`default_nettype wire

// File: tb/tb_fc_argmax_top2.sv
// ============================================================================
//  Module  : tb_fc_argmax_top2
//  Purpose : Self-checking bench for fc_argmax_top2 with NUM_CLASSES=4,
//            DATA_W=16. Expected results are queued as each frame's last
//            beat is driven and checked when valid_result pulses.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_argmax_top2;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic signed [DW-1:0] score_in;
  logic                 clear;
  logic                 busy;
  logic                 valid_result;
  logic        [IW-1:0] class_idx;
  logic signed [DW-1:0] class_score;
  logic        [IW-1:0] second_idx;
  logic signed [DW-1:0] second_score;

  fc_argmax_top2 #(
    .NUM_CLASSES (NC),
    .DATA_W      (DW),
    .IDX_W       (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .score_in     (score_in),
    .clear        (clear),
    .busy         (busy),
    .valid_result (valid_result),
    .class_idx    (class_idx),
    .class_score  (class_score),
    .second_idx   (second_idx),
    .second_score (second_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx1;
    int sc1;
    int idx2;
    int sc2;
  } res_t;

  typedef struct {
    int   s0;
    int   s1;
    int   s2;
    int   s3;
    int   max_gap;
    res_t e;
  } vec_t;

  res_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  int   n_frames = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest queued result.
  res_t mon_e;
  always @(negedge clk) begin
    if (valid_result === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse, expected none (idx %0d score %0d)",
                 class_idx, class_score);
      end else begin
        mon_e = exp_q.pop_front();
        chk("class_idx",    {30'd0, class_idx},     mon_e.idx1);
        chk("class_score",  $signed(class_score),   mon_e.sc1);
        chk("second_idx",   {30'd0, second_idx},    mon_e.idx2);
        chk("second_score", $signed(second_score),  mon_e.sc2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d,
                            input int max_gap, input res_t e);
    int s[4];
    int g;
    s = '{a, b, c, d};
    for (int i = 0; i < NC; i++) begin
      valid_in = 1'b1;
      score_in = DW'(s[i]);
      if (i == NC - 1) begin
        exp_q.push_back(e);
        n_frames++;
      end
      tick();
      valid_in = 1'b0;
      if (i == 0) chk("busy_after_first", {31'd0, busy}, 1);
      if (i == NC - 1) chk("busy_after_last", {31'd0, busy}, 0);
      if (i < NC - 1 && max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        repeat (g) begin
          tick();
          chk("busy_in_gap", {31'd0, busy}, 1);
        end
      end
    end
  endtask

  // Bounded wait for all queued results to be consumed.
  task automatic drain();
    for (int k = 0; k < 6 && exp_q.size() != 0; k++) tick();
    chk("results_drained", exp_q.size(), 0);
    tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},         {31'd0, busy},          0);
    chk({tag, "_valid_result"}, {31'd0, valid_result},  0);
    chk({tag, "_class_idx"},    {30'd0, class_idx},     0);
    chk({tag, "_class_score"},  $signed(class_score),   0);
    chk({tag, "_second_idx"},   {30'd0, second_idx},    0);
    chk({tag, "_second_score"}, $signed(second_score),  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[6];
  int   p0;

  initial begin
    tbl[0] = '{5, -3, 12, 7, 0, '{2, 12, 3, 7}};
    tbl[1] = '{9, 9, 1, 9, 0, '{0, 9, 1, 9}};
    tbl[2] = '{-32768, -32768, -32768, -32768, 0, '{0, -32768, 1, -32768}};
    tbl[3] = '{1, 4, 2, 3, 5, '{1, 4, 3, 3}};
    tbl[4] = '{-1, -2, -3, -4, 2, '{0, -1, 1, -2}};
    tbl[5] = '{32767, -32768, 32767, 0, 1, '{0, 32767, 2, 32767}};

    rst      = 1'b1;
    valid_in = 1'b0;
    clear    = 1'b0;
    score_in = '0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      send_frame(tbl[v].s0, tbl[v].s1, tbl[v].s2, tbl[v].s3, tbl[v].max_gap, tbl[v].e);
      drain();
    end

    // Back-to-back: frame A's pulse is visible while frame B beat 0 is driven.
    send_frame(3, 1, 2, 0, 0, '{0, 3, 2, 2});
    chk("pulse_with_next_beat0", {31'd0, valid_result}, 1);
    send_frame(-4, 6, 6, -9, 0, '{1, 6, 2, 6});
    drain();

    // Clear mid-frame keeps published outputs and produces no pulse.
    send_frame(8, 0, 0, 0, 0, '{0, 8, 1, 0});
    drain();
    p0 = n_pulses;
    valid_in = 1'b1; score_in = 16'sd50; tick();
    valid_in = 1'b1; score_in = 16'sd60; tick();
    // Coincident beat must be dropped in favour of clear.
    valid_in = 1'b1; clear = 1'b1; score_in = 16'sd99; tick();
    valid_in = 1'b0; clear = 1'b0;
    chk("busy_after_clear", {31'd0, busy}, 0);
    repeat (3) tick();
    chk("no_pulse_after_clear", n_pulses, p0);
    chk("held_class_idx",   {30'd0, class_idx},   0);
    chk("held_class_score", $signed(class_score), 8);
    send_frame(1, 2, 3, 4, 0, '{3, 4, 2, 3});
    drain();

    // Reset mid-frame clears everything; the following frame is clean.
    valid_in = 1'b1; score_in = 16'sd7; tick();
    valid_in = 1'b1; score_in = 16'sd9; tick();
    valid_in = 1'b0; rst = 1'b1; tick();
    chk_outputs_zero("midreset");
    rst = 1'b0;
    tick();
    send_frame(-5, 10, -7, 10, 0, '{1, 10, 3, 10});
    drain();

    chk("total_pulses", n_pulses, n_frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fc_argmax_top2

`default_nettype wire
